// File: rtl/nn_pkg.sv
//------------------------------------------------------------------------------
// nn_pkg : opcodes, FSM state encoding and saturation limits for nn_vector_engine
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nn_pkg;

  typedef enum logic [1:0] {
    OP_DOT  = 2'b00,
    OP_MAX  = 2'b01,
    OP_SUM  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCUM  = 2'b01,
    ST_OUTPUT = 2'b10
  } state_e;

  // Signed range of a w-bit two's complement result.
  function automatic longint sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/nn_vector_engine_if.sv
//------------------------------------------------------------------------------
// nn_vector_engine_if : command, input-beat and result handshake bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface nn_vector_engine_if #(
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic                      start_i;
  logic [1:0]                op_i;
  logic [LEN_W-1:0]          len_i;
  logic signed [DATA_W-1:0]  bias_i;
  logic [4:0]                shift_i;
  logic                      relu_en_i;
  logic                      busy_o;
  logic                      in_valid_i;
  logic                      in_ready_o;
  logic [DATA_W*LANES-1:0]   data_i;
  logic [DATA_W*LANES-1:0]   weight_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic signed [DATA_W-1:0]  result_o;
  logic signed [ACC_W-1:0]   acc_o;
  logic                      err_o;

  modport slave (
    input  start_i, op_i, len_i, bias_i, shift_i, relu_en_i,
    input  in_valid_i, data_i, weight_i, out_ready_i,
    output busy_o, in_ready_o, out_valid_o, result_o, acc_o, err_o
  );

  modport master (
    output start_i, op_i, len_i, bias_i, shift_i, relu_en_i,
    output in_valid_i, data_i, weight_i, out_ready_i,
    input  busy_o, in_ready_o, out_valid_o, result_o, acc_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/nn_lane_mac.sv
//------------------------------------------------------------------------------
// nn_lane_mac : per-beat LANES-wide dot/sum/max reduction to an ACC_W value
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nn_lane_mac
  import nn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 24
) (
  input  wire [1:0]                op_i,
  input  wire [DATA_W*LANES-1:0]   data_i,
  input  wire [DATA_W*LANES-1:0]   weight_i,
  output logic signed [ACC_W-1:0]  beat_o
);

  logic signed [ACC_W-1:0] prod_ext [LANES];
  logic signed [ACC_W-1:0] data_ext [LANES];
  logic signed [ACC_W-1:0] sum_v;
  logic signed [ACC_W-1:0] max_v;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0]   d_v;
    logic signed [DATA_W-1:0]   w_v;
    logic signed [2*DATA_W-1:0] p_v;
    assign d_v         = data_i[l*DATA_W +: DATA_W];
    assign w_v         = weight_i[l*DATA_W +: DATA_W];
    assign p_v         = d_v * w_v;
    assign prod_ext[l] = ACC_W'(p_v);
    assign data_ext[l] = ACC_W'(d_v);
  end

  always_comb begin
    sum_v = '0;
    max_v = data_ext[0];
    for (int l = 0; l < LANES; l++) begin
      sum_v = sum_v + ((op_e'(op_i) == OP_DOT) ? prod_ext[l] : data_ext[l]);
      if (data_ext[l] > max_v) max_v = data_ext[l];
    end
    beat_o = (op_e'(op_i) == OP_MAX) ? max_v : sum_v;
  end

endmodule

`default_nettype wire

// File: rtl/nn_vector_engine.sv
//------------------------------------------------------------------------------
// nn_vector_engine : streaming DOT/MAX/SUM vector engine with requantised output
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nn_vector_engine
  import nn_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LANES   = 4,
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 16,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input wire clk_i,
  input wire rst_n_i,
  nn_vector_engine_if.slave bus
);

  // Finalise width holds acc plus a bias shifted by up to 31 without loss.
  localparam int FIN_W = ACC_W + DATA_W + 32;
  localparam logic signed [FIN_W-1:0]  SAT_HI   = FIN_W'(sat_hi(DATA_W));
  localparam logic signed [FIN_W-1:0]  SAT_LO   = FIN_W'(sat_lo(DATA_W));
  localparam logic signed [ACC_W-1:0]  MAX_INIT = ACC_W'(sat_lo(DATA_W));

  state_e                   state_q, state_d;
  op_e                      op_q, op_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic [4:0]               shift_q, shift_d;
  logic                     relu_q, relu_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic signed [DATA_W-1:0] result_q, result_d;
  logic                     err_q, err_d;

  logic signed [ACC_W-1:0]  beat_val;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [FIN_W-1:0]  fin_acc, fin_bias, fin_sum, fin_t;
  logic signed [DATA_W-1:0] fin_res;
  logic                     cmd_legal;
  logic [LEN_W-1:0]         cnt_inc;

  nn_lane_mac #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .ACC_W  (ACC_W)
  ) u_lane_mac (
    .op_i     (op_q),
    .data_i   (bus.data_i),
    .weight_i (bus.weight_i),
    .beat_o   (beat_val)
  );

  always_comb begin
    acc_nxt = (op_q == OP_MAX) ? ((beat_val > acc_q) ? beat_val : acc_q)
                               : (acc_q + beat_val);
  end

  // Finalise is taken from acc_nxt so the result registers on the last beat.
  always_comb begin
    fin_acc  = FIN_W'(acc_nxt);
    fin_bias = FIN_W'(bias_q);
    fin_sum  = fin_acc + (fin_bias <<< shift_q);
    fin_t    = (op_q == OP_MAX) ? fin_acc : (fin_sum >>> shift_q);
    if (relu_q && (fin_t < 0)) fin_t = '0;
    if (fin_t > SAT_HI)      fin_res = SAT_HI[DATA_W-1:0];
    else if (fin_t < SAT_LO) fin_res = SAT_LO[DATA_W-1:0];
    else                     fin_res = fin_t[DATA_W-1:0];
  end

  assign cmd_legal = (op_e'(bus.op_i) != OP_RSVD) && (bus.len_i != '0) &&
                     (bus.len_i <= LEN_W'(MAX_LEN));
  assign cnt_inc   = cnt_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    bias_d    = bias_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    result_d  = result_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          op_d    = op_e'(bus.op_i);
          len_d   = bus.len_i;
          bias_d  = bus.bias_i;
          shift_d = bus.shift_i;
          relu_d  = bus.relu_en_i;
          cnt_d   = '0;
          acc_d   = (op_e'(bus.op_i) == OP_MAX) ? MAX_INIT : '0;
          if (cmd_legal) begin
            state_d = ST_ACCUM;
          end else begin
            state_d   = ST_OUTPUT;
            result_d  = '0;
            acc_out_d = '0;
            err_d     = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid_i) begin
          acc_d = acc_nxt;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d   = ST_OUTPUT;
            result_d  = fin_res;
            acc_out_d = acc_nxt;
            err_d     = 1'b0;
          end
        end
      end
      ST_OUTPUT: begin
        if (bus.out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_DOT;
      len_q     <= '0;
      cnt_q     <= '0;
      bias_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      acc_q     <= '0;
      acc_out_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      bias_q    <= bias_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.in_ready_o  = (state_q == ST_ACCUM);
  assign bus.out_valid_o = (state_q == ST_OUTPUT);
  assign bus.result_o    = result_q;
  assign bus.acc_o       = acc_out_q;
  assign bus.err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_nn_vector_engine.sv
//------------------------------------------------------------------------------
// tb_nn_vector_engine : directed and randomized checks against a reference model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_nn_vector_engine;

  localparam int DW = 8;
  localparam int LN = 4;
  localparam int AW = 24;
  localparam int ML = 16;
  localparam int LW = $clog2(ML + 1);

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   d_arr [ML][LN];
  int   w_arr [ML][LN];

  nn_vector_engine_if #(.DATA_W(DW), .LANES(LN), .ACC_W(AW), .MAX_LEN(ML)) bus ();

  nn_vector_engine #(.DATA_W(DW), .LANES(LN), .ACC_W(AW), .MAX_LEN(ML)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    longint m;
    m = x & ((64'sd1 <<< AW) - 1);
    if (m >= (64'sd1 <<< (AW - 1))) m = m - (64'sd1 <<< AW);
    return m;
  endfunction

  // Reference: straight arithmetic on the beat arrays.
  task automatic model(input int op, input int len, input int bias, input int shift,
                       input bit relu, output longint res, output longint acc);
    longint t;
    acc = (op == 1) ? -(64'sd1 <<< (DW - 1)) : 64'sd0;
    for (int b = 0; b < len; b++) begin
      for (int l = 0; l < LN; l++) begin
        if (op == 0)      acc = wrap(acc + longint'(d_arr[b][l] * w_arr[b][l]));
        else if (op == 2) acc = wrap(acc + longint'(d_arr[b][l]));
        else if (longint'(d_arr[b][l]) > acc) acc = longint'(d_arr[b][l]);
      end
    end
    if (op == 1) t = acc;
    else         t = (acc + (longint'(bias) <<< shift)) >>> shift;
    if (relu && t < 0) t = 0;
    if (t > (64'sd1 <<< (DW - 1)) - 1) t = (64'sd1 <<< (DW - 1)) - 1;
    if (t < -(64'sd1 <<< (DW - 1)))    t = -(64'sd1 <<< (DW - 1));
    res = t;
  endtask

  task automatic drive_beat(input int b);
    for (int l = 0; l < LN; l++) begin
      bus.data_i[l*DW +: DW]   = DW'(d_arr[b][l]);
      bus.weight_i[l*DW +: DW] = DW'(w_arr[b][l]);
    end
  endtask

  task automatic do_cmd(input int op, input int len, input int bias, input int shift,
                        input bit relu, input bit gaps, input int hold, input string tag);
    longint er, ea;
    bit     bad;
    int     g;
    bad = (op == 3) || (len == 0) || (len > ML);
    er  = 0;
    ea  = 0;
    if (!bad) model(op, len, bias, shift, relu, er, ea);
    bus.start_i   = 1'b1;
    bus.op_i      = 2'(op);
    bus.len_i     = LW'(len);
    bus.bias_i    = DW'(bias);
    bus.shift_i   = 5'(shift);
    bus.relu_en_i = relu;
    tick();
    bus.start_i = 1'b0;
    chk({tag, " busy"}, longint'(bus.busy_o), 1);
    if (!bad) begin
      for (int b = 0; b < len; b++) begin
        if (gaps) begin
          g = int'($urandom_range(0, 2));
          for (int k = 0; k < g; k++) begin
            bus.in_valid_i = 1'b0;
            bus.start_i    = 1'b1;
            bus.op_i       = 2'(3);
            tick();
            bus.start_i = 1'b0;
            chk({tag, " gap no out_valid"}, longint'(bus.out_valid_o), 0);
          end
        end
        bus.in_valid_i = 1'b1;
        drive_beat(b);
        chk({tag, " in_ready"}, longint'(bus.in_ready_o), 1);
        tick();
        bus.in_valid_i = 1'b0;
        if (b < len - 1) chk({tag, " early out_valid"}, longint'(bus.out_valid_o), 0);
      end
    end
    chk({tag, " out_valid"}, longint'(bus.out_valid_o), 1);
    chk({tag, " in_ready low"}, longint'(bus.in_ready_o), 0);
    chk({tag, " err"}, longint'(bus.err_o), longint'(bad));
    chk({tag, " result"}, longint'(bus.result_o), er);
    chk({tag, " acc"}, longint'(bus.acc_o), ea);
    for (int h = 0; h < hold; h++) begin
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      chk({tag, " hold out_valid"}, longint'(bus.out_valid_o), 1);
      chk({tag, " hold result"}, longint'(bus.result_o), er);
      chk({tag, " hold acc"}, longint'(bus.acc_o), ea);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    chk({tag, " idle busy"}, longint'(bus.busy_o), 0);
    chk({tag, " idle out_valid"}, longint'(bus.out_valid_o), 0);
  endtask

  task automatic fill_const(input int dv, input int wv);
    for (int b = 0; b < ML; b++)
      for (int l = 0; l < LN; l++) begin
        d_arr[b][l] = dv;
        w_arr[b][l] = wv;
      end
  endtask

  task automatic fill_rand();
    for (int b = 0; b < ML; b++)
      for (int l = 0; l < LN; l++) begin
        d_arr[b][l] = int'($urandom_range(0, 255)) - 128;
        w_arr[b][l] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, longint'(bus.busy_o), 0);
    chk({tag, " in_ready"}, longint'(bus.in_ready_o), 0);
    chk({tag, " out_valid"}, longint'(bus.out_valid_o), 0);
    chk({tag, " result"}, longint'(bus.result_o), 0);
    chk({tag, " acc"}, longint'(bus.acc_o), 0);
    chk({tag, " err"}, longint'(bus.err_o), 0);
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.op_i        = '0;
    bus.len_i       = '0;
    bus.bias_i      = '0;
    bus.shift_i     = '0;
    bus.relu_en_i   = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.data_i      = '0;
    bus.weight_i    = '0;
    bus.out_ready_i = 1'b0;
    rst_n_i         = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst_n_i = 1'b1;
    tick();

    fill_const(1, 2);
    do_cmd(0, 1, 1, 0, 1'b0, 1'b0, 0, "dot_len1");

    d_arr[0] = '{-5, 3, -1, 7};
    d_arr[1] = '{2, -8, 6, 0};
    do_cmd(1, 2, 0, 0, 1'b1, 1'b0, 0, "max_relu");
    d_arr[0] = '{-5, -3, -1, -7};
    d_arr[1] = '{-2, -8, -6, -100};
    do_cmd(1, 2, 0, 0, 1'b1, 1'b0, 0, "max_allneg");

    fill_const(100, 0);
    do_cmd(2, 4, 0, 2, 1'b0, 1'b0, 0, "sum_pos_sat");
    fill_const(-100, 0);
    do_cmd(2, 4, 0, 2, 1'b0, 1'b0, 0, "sum_neg_sat");

    do_cmd(3, 2, 5, 0, 1'b0, 1'b0, 0, "err_op");
    do_cmd(0, 0, 5, 0, 1'b0, 1'b0, 0, "err_len0");
    do_cmd(2, ML + 1, 5, 0, 1'b0, 1'b0, 0, "err_len_big");

    fill_rand();
    do_cmd(0, 3, -7, 1, 1'b0, 1'b1, 5, "dot_gaps_hold");

    // Abort a 4-beat DOT after two beats, then rerun with fresh data.
    fill_const(50, 50);
    do_cmd(2, 1, 0, 0, 1'b0, 1'b0, 0, "pre_reset");
    bus.start_i = 1'b1;
    bus.op_i    = 2'(0);
    bus.len_i   = LW'(4);
    bus.bias_i  = '0;
    bus.shift_i = '0;
    tick();
    bus.start_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid_i = 1'b1;
      drive_beat(b);
      tick();
    end
    rst_n_i = 1'b0;
    tick();
    chk_zero("mid_reset");
    rst_n_i        = 1'b1;
    bus.in_valid_i = 1'b0;
    tick();
    fill_rand();
    do_cmd(0, 4, 3, 0, 1'b0, 1'b0, 0, "post_reset");

    for (int i = 0; i < 25; i++) begin
      fill_rand();
      do_cmd(int'($urandom_range(0, 2)), int'($urandom_range(1, ML)),
             int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 10)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
